// File: rtl/led_pkg.sv
// Shared encodings and the triangular level function for the LED breathing array.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_LOOP    = 2'd1,
    MODE_CHASE   = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Expects x < 2*pk, so the falling half never goes negative.
  function automatic int unsigned tri_level(input int unsigned x, input int unsigned pk);
    return (x <= pk) ? x : (2 * pk - x);
  endfunction

endpackage

// File: rtl/led_breath_array_if.sv
// Control/status bundle between the sequencer (master) and the breathing array (slave).
interface led_breath_array_if #(
  parameter int N_CH = 4,
  parameter int DC_W = 4
);
  logic                   start;
  logic                   stop;
  logic [1:0]             mode;
  logic [N_CH-1:0]        pwm_out;
  logic [N_CH*DC_W-1:0]   duty;
  logic                   busy;
  logic                   peak;
  logic                   done;

  modport master (
    output start, stop, mode,
    input  pwm_out, duty, busy, peak, done
  );

  modport slave (
    input  start, stop, mode,
    output pwm_out, duty, busy, peak, done
  );
endinterface

// File: rtl/led_pwm_chan.sv
// One PWM channel: registered unsigned compare of the shared frame counter against the duty.
module led_pwm_chan #(
  parameter int CNT_W = 4,
  parameter int DC_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] pwm_cnt_i,
  input  logic [DC_W-1:0]  duty_i,
  output logic             pwm_o
);
  logic pwm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= (32'(pwm_cnt_i) < 32'(duty_i));
  end

  assign pwm_o = pwm_q;
endmodule

// File: rtl/led_breath_array.sv
// Multi-channel breathing controller: shared step/phase timer, per-channel triangular duty
// and PWM, with one-shot, loop and chase modes plus a stop request honoured at the wrap.
module led_breath_array
  import led_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DC_W       = 4,
  parameter int PEAK       = 10,
  parameter int PWM_PERIOD = 10,
  parameter int STEP_TICKS = 20,
  parameter int CH_OFFSET  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  led_breath_array_if.slave bus
);
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int PH_W   = $clog2(2 * PEAK);
  localparam int CNT_W  = $clog2(PWM_PERIOD + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * PEAK - 1);
  localparam logic [PH_W-1:0]   PH_PEAK   = PH_W'(PEAK);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [N_CH*DC_W-1:0] duty_q, duty_d;
  logic                 peak_q, peak_d;
  logic                 done_q, done_d;
  logic [N_CH-1:0]      pwm_w;
  logic                 step_tick, wrap, finish;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    step_d      = step_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;

    step_tick = (state_q == ST_RUN) && (step_q == STEP_LAST);
    wrap      = step_tick && (phase_q == PH_LAST);
    // A stop on the wrap cycle itself still ends the run at that wrap.
    finish    = wrap && ((mode_q == MODE_ONESHOT) || stop_pend_q || bus.stop);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          mode_d      = (bus.mode == MODE_LOOP)  ? MODE_LOOP  :
                        (bus.mode == MODE_CHASE) ? MODE_CHASE : MODE_ONESHOT;
          step_d      = '0;
          phase_d     = '0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.stop) stop_pend_d = 1'b1;
        step_d = step_tick ? '0 : step_q + STEP_W'(1);
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (step_tick) phase_d = wrap ? '0 : phase_q + PH_W'(1);
        if (finish) begin
          state_d     = ST_IDLE;
          step_d      = '0;
          phase_d     = '0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    peak_d = (state_d == ST_RUN) && (phase_d == PH_PEAK) && (step_d == '0);
  end

  // Duty and PWM compare both use next-state values so they line up with phase and pwm_cnt.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam int unsigned OFS = (gi * CH_OFFSET) % (2 * PEAK);
    int unsigned     pos;
    logic [DC_W-1:0] lvl_d;

    assign pos   = (mode_d == MODE_CHASE) ? (32'(phase_d) + OFS) % (2 * PEAK) : 32'(phase_d);
    assign lvl_d = (state_d == ST_RUN) ? DC_W'(tri_level(pos, PEAK)) : '0;
    assign duty_d[gi*DC_W +: DC_W] = lvl_d;

    led_pwm_chan #(
      .CNT_W (CNT_W),
      .DC_W  (DC_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt_i (cnt_d),
      .duty_i    (lvl_d),
      .pwm_o     (pwm_w[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ONESHOT;
      step_q      <= '0;
      phase_q     <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      duty_q      <= '0;
      peak_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      duty_q      <= duty_d;
      peak_q      <= peak_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy    = (state_q == ST_RUN);
  assign bus.duty    = duty_q;
  assign bus.peak    = peak_q;
  assign bus.done    = done_q;
  assign bus.pwm_out = pwm_w;
endmodule

// File: tb/tb_led_breath_array.sv
// Scoreboard bench for led_breath_array: a run-time based model queues expected outputs per edge.
module tb_led_breath_array;
  localparam int NC  = 4;
  localparam int DW  = 4;
  localparam int PK  = 4;
  localparam int ST  = 3;
  localparam int PER = 8;
  localparam int OFS = 2;
  localparam int CYC = 2 * PK * ST;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          peak;
    logic [NC*DW-1:0] duty;
    logic [NC-1:0] pwm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  led_breath_array_if #(.N_CH(NC), .DC_W(DW)) bus ();

  led_breath_array #(
    .N_CH(NC), .DC_W(DW), .PEAK(PK), .PWM_PERIOD(PER), .STEP_TICKS(ST), .CH_OFFSET(OFS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state: run time m_t counts RUN cycles since start; everything derives from it.
  int m_busy = 0, m_done = 0, m_t = 0, m_pend = 0;
  logic [1:0] m_mode = 2'd0;

  task automatic model_step(input logic s, input logic sp, input logic [1:0] m, input logic r);
    exp_t e;
    int ph, stp, cnt, x, lvl;
    m_done = 0;
    if (!r) begin
      m_busy = 0; m_t = 0; m_pend = 0; m_mode = 2'd0;
    end else if (m_busy == 0) begin
      if (s) begin
        m_busy = 1; m_t = 0; m_pend = 0;
        m_mode = (m == 2'd3) ? 2'd0 : m;
      end
    end else begin
      if (sp) m_pend = 1;
      m_t++;
      if ((m_t % CYC) == 0 && (m_mode == 2'd0 || m_pend != 0)) begin
        m_busy = 0; m_done = 1; m_pend = 0; m_t = 0;
      end
    end
    ph  = (m_t / ST) % (2 * PK);
    stp = m_t % ST;
    cnt = m_t % PER;
    e.busy = (m_busy != 0);
    e.done = (m_done != 0);
    e.peak = (m_busy != 0) && ph == PK && stp == 0;
    for (int ch = 0; ch < NC; ch++) begin
      x = (m_mode == 2'd2) ? (ph + ch * OFS) % (2 * PK) : ph;
      lvl = (x <= PK) ? x : 2 * PK - x;
      if (m_busy == 0) lvl = 0;
      e.duty[ch*DW +: DW] = DW'(lvl);
      e.pwm[ch] = (m_busy != 0) && (cnt < lvl);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic s, input logic sp, input logic [1:0] m, input logic r);
    bus.start = s; bus.stop = sp; bus.mode = m; rst_n = r;
    @(posedge clk);
    model_step(s, sp, m, r);
    #1;
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val("busy", 32'(bus.busy), 32'(e.busy));
      check_val("done", 32'(bus.done), 32'(e.done));
      check_val("peak", 32'(bus.peak), 32'(e.peak));
      check_val("duty", 32'(bus.duty), 32'(e.duty));
      check_val("pwm",  32'(bus.pwm_out), 32'(e.pwm));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int peak_n, peak_c, done_c;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'd0;

    // Reset held with start asserted, then idle without a fresh start
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'd0, 1'b1);
    check_val("idle_after_rst", 32'(bus.busy), 32'd0);
    $display("reset: busy=%0b duty=%0h pwm=%0h", bus.busy, bus.duty, bus.pwm_out);

    // ONESHOT: peak at cycle 13 only, done at cycle 25
    peak_n = 0; peak_c = -1; done_c = -1;
    tick(1'b1, 1'b0, 2'd0, 1'b1);
    for (int c = 1; c <= 28; c++) begin
      if (bus.peak) begin peak_n++; peak_c = c; end
      if (bus.done && done_c < 0) done_c = c;
      tick(1'b0, 1'b0, 2'd0, 1'b1);
    end
    check_val("os_peak_cnt", 32'(peak_n), 32'd1);
    check_val("os_peak_cyc", 32'(peak_c), 32'd13);
    check_val("os_done_cyc", 32'(done_c), 32'd25);
    $display("oneshot: peak_cyc=%0d done_cyc=%0d", peak_c, done_c);

    // CHASE: initial channel spread and one step later, then stop
    tick(1'b1, 1'b0, 2'd2, 1'b1);
    check_val("chase_first", 32'(bus.duty), 32'h2420);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'd0, 1'b1);
    check_val("chase_step1", 32'(bus.duty), 32'h1331);
    for (int i = 0; i < 30; i++) tick(1'b0, (i == 5), 2'd0, 1'b1);
    for (int i = 0; i < 25 && bus.busy; i++) tick(1'b0, 1'b0, 2'd0, 1'b1);
    $display("chase: ended busy=%0b", bus.busy);

    // LOOP with stop at phase 5 and an ignored second start
    done_c = -1;
    tick(1'b1, 1'b0, 2'd1, 1'b1);
    for (int c = 1; c <= 28; c++) begin
      if (bus.done && done_c < 0) done_c = c;
      tick((c == 5), (c == 16), 2'd0, 1'b1);
    end
    check_val("loop_stop_done", 32'(done_c), 32'd25);
    $display("loop+stop: done_cyc=%0d", done_c);

    // LOOP across one wrap, stop on the second wrap cycle itself
    done_c = -1;
    tick(1'b1, 1'b0, 2'd1, 1'b1);
    for (int c = 1; c <= 52; c++) begin
      if (bus.done && done_c < 0) done_c = c;
      tick(1'b0, (c == 48), 2'd0, 1'b1);
    end
    check_val("loop_wrap_stop", 32'(done_c), 32'd49);
    $display("loop wrap-stop: done_cyc=%0d", done_c);

    // Reserved mode behaves as ONESHOT
    tick(1'b1, 1'b0, 2'd3, 1'b1);
    for (int c = 1; c <= 27; c++) tick(1'b0, 1'b0, 2'd0, 1'b1);
    $display("mode3: busy=%0b", bus.busy);

    // Reset mid-run at phase 3: no done pulse
    tick(1'b1, 1'b0, 2'd0, 1'b1);
    for (int c = 1; c < 10; c++) tick(1'b0, 1'b0, 2'd0, 1'b1);
    tick(1'b0, 1'b0, 2'd0, 1'b0);
    check_val("rst_mid_busy", 32'(bus.busy), 32'd0);
    check_val("rst_mid_done", 32'(bus.done), 32'd0);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 2'd0, 1'b1);
    $display("reset mid-run: busy=%0b done=%0b", bus.busy, bus.done);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
